// File: rtl/fmad_acc_drain_if.sv
// Drain-side bundle between the fmad accumulators, their reader and the binary32 result stream.
interface fmad_acc_drain_if;
    logic        start;
    logic [3:0]  lane_en;
    logic [31:0] acc0;
    logic [31:0] acc1;
    logic [31:0] acc2;
    logic [31:0] acc3;
    logic [9:0]  exp0;
    logic [9:0]  exp1;
    logic [9:0]  exp2;
    logic [9:0]  exp3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flag;
    logic [1:0]  out_idx;
    logic        busy;
    logic        done;

    modport master (
        output start, lane_en, acc0, acc1, acc2, acc3, exp0, exp1, exp2, exp3, out_ready,
        input  out_valid, out_data, out_flag, out_idx, busy, done
    );

    modport slave (
        input  start, lane_en, acc0, acc1, acc2, acc3, exp0, exp1, exp2, exp3, out_ready,
        output out_valid, out_data, out_flag, out_idx, busy, done
    );
endinterface

// File: rtl/fmad_acc_drain.sv
// Snapshots four block-float accumulator lanes and streams each enabled lane out as RNE binary32.
// First result valid 3 edges after start; each later lane 3 edges after the previous handshake.
module fmad_acc_drain #(
    parameter int ACC_FRAC = 30,
    parameter int EXP_BIAS = 254
) (
    input  logic             clk,
    input  logic             reset,
    fmad_acc_drain_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, NORM, ROUND, OUT, FIN} state_t;

    state_t            state;
    logic [3:0][31:0]  snap_acc;
    logic [3:0][9:0]   snap_exp;
    logic [3:0]        snap_en;
    logic [1:0]        lane;

    logic              n_sign;
    logic [31:0]       n_mag;
    logic [4:0]        n_p;
    logic signed [11:0] n_e;

    logic [31:0]       r_data;
    logic [4:0]        r_flag;

    // Normalisation of the currently selected lane
    logic [31:0]       cur_acc;
    logic [9:0]        cur_exp;
    logic [31:0]       c_mag;
    logic [4:0]        c_p;
    logic signed [11:0] c_e;

    always_comb begin
        cur_acc = snap_acc[lane];
        cur_exp = snap_exp[lane];
        c_mag   = cur_acc[31] ? (~cur_acc + 32'd1) : cur_acc;
        c_p     = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (c_mag[i]) c_p = 5'(i);
        end
        c_e = {{2{cur_exp[9]}}, cur_exp} - 12'(EXP_BIAS + ACC_FRAC) + {7'b0, c_p};
    end

    // Lane sequencing: lowest enabled lane at start, next higher one after each handshake
    logic [1:0] first_lane;
    logic [1:0] nxt_lane;
    logic       nxt_found;

    always_comb begin
        first_lane = 2'd0;
        nxt_lane   = lane;
        nxt_found  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.lane_en[i]) first_lane = 2'(i);
            if (snap_en[i] && i > int'(lane)) begin
                nxt_found = 1'b1;
                nxt_lane  = 2'(i);
            end
        end
    end

    // Rounding: subnormals reuse the normal datapath with an extra right shift
    logic               sub;
    logic signed [11:0] sub_d;
    logic [4:0]         sh;
    logic [31:0]        norm;
    logic [57:0]        v;
    logic [23:0]        kept;
    logic               guard;
    logic               sticky;
    logic               inexact;
    logic [24:0]        rnd;
    logic [9:0]         base;
    logic [32:0]        sum;
    logic [9:0]         field;
    logic [31:0]        c_data;
    logic [4:0]         c_flag;

    always_comb begin
        sub     = n_e < -12'sd126;
        sub_d   = -12'sd126 - n_e;
        sh      = 5'd0;
        if (sub) sh = (sub_d > 12'sd26) ? 5'd26 : sub_d[4:0];
        norm    = n_mag << (5'd31 - n_p);
        v       = {norm, 26'b0} >> sh;
        kept    = v[57:34];
        guard   = v[33];
        sticky  = |v[32:0];
        inexact = guard | sticky;
        rnd     = {1'b0, kept} + {24'b0, guard & (sticky | kept[0])};
        // The hidden bit in rnd bumps the exponent, so base is one below the biased exponent.
        base    = sub ? 10'd0 : 10'(n_e + 12'sd126);
        sum     = {base, 23'b0} + {8'b0, rnd};
        field   = sum[32:23];
        c_data  = 32'd0;
        c_flag  = 5'd0;
        if (n_mag == 32'd0) begin
            c_data = 32'd0;
            c_flag = 5'd0;
        end else if (field >= 10'd255) begin
            c_data = {n_sign, 8'hFF, 23'd0};
            c_flag = 5'b00101;
        end else begin
            c_data = {n_sign, sum[30:0]};
            c_flag = {3'b000, (field == 10'd0) & inexact, inexact};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            snap_acc      <= '0;
            snap_exp      <= '0;
            snap_en       <= '0;
            lane          <= 2'd0;
            n_sign        <= 1'b0;
            n_mag         <= '0;
            n_p           <= '0;
            n_e           <= '0;
            r_data        <= '0;
            r_flag        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_flag  <= '0;
            bus.out_idx   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap_acc <= {bus.acc3, bus.acc2, bus.acc1, bus.acc0};
                        snap_exp <= {bus.exp3, bus.exp2, bus.exp1, bus.exp0};
                        snap_en  <= bus.lane_en;
                        bus.busy <= 1'b1;
                        if (bus.lane_en == 4'd0) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            lane  <= first_lane;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    n_sign <= cur_acc[31];
                    n_mag  <= c_mag;
                    n_p    <= c_p;
                    n_e    <= c_e;
                    state  <= ROUND;
                end
                ROUND: begin
                    r_data <= c_data;
                    r_flag <= c_flag;
                    state  <= OUT;
                end
                OUT: begin
                    // First OUT cycle registers the result; valid then holds until accepted.
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= r_data;
                        bus.out_flag  <= r_flag;
                        bus.out_idx   <= lane;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (nxt_found) begin
                            lane  <= nxt_lane;
                            state <= NORM;
                        end else begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmad_acc_drain.sv
// Bench for fmad_acc_drain: directed value table, latency/hold/reset sequences and random drains.
module tb_fmad_acc_drain;
    localparam int ACC_FRAC = 30;
    localparam int EXP_BIAS = 254;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fmad_acc_drain_if bus();
    fmad_acc_drain #(.ACC_FRAC(ACC_FRAC), .EXP_BIAS(EXP_BIAS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] acc;
        logic [9:0]  exp;
        logic [31:0] data;
        logic [4:0]  flag;
    } vec_t;

    vec_t        tbl[16];
    logic [31:0] va[4];
    logic [9:0]  ve[4];
    logic [31:0] ed_arr[4];
    logic [4:0]  ef_arr[4];
    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // value = mag * 2^s; pick the binary32 ulp exponent u, divide, round half to even.
    function automatic void ref_conv(input logic [31:0] a, input logic [9:0] e,
                                     output logic [31:0] d, output logic [4:0] f);
        longint mag, q, rem, half;
        int s, msb, u, k, field;
        bit sgn, inexact;
        sgn = a[31];
        mag = sgn ? -longint'($signed(a)) : longint'(a);
        d = 32'd0;
        f = 5'd0;
        if (mag == 0) return;
        s = int'($signed(e)) - (EXP_BIAS + ACC_FRAC);
        msb = 0;
        for (int i = 0; i < 40; i++) if (mag[i]) msb = i;
        u = msb + s - 23;
        if (u < -149) u = -149;
        k = u - s;
        if (k <= 0) begin
            q = mag << (-k); rem = 0; half = 1;
        end else if (k > 40) begin
            q = 0; rem = 1; half = 2;
        end else begin
            q = mag >> k;
            rem = mag & ((longint'(1) << k) - 1);
            half = longint'(1) << (k - 1);
        end
        inexact = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (q >= longint'(32'h0100_0000)) begin q = q >> 1; u++; end
        field = (q < longint'(32'h0080_0000)) ? 0 : u + 150;
        if (field >= 255) begin
            d = {sgn, 8'hFF, 23'd0};
            f = 5'b00101;
        end else begin
            d = {sgn, 8'(field), 23'(q)};
            f = {3'b000, (field == 0) && inexact, inexact};
        end
    endfunction

    task automatic drive_lanes();
        bus.acc0 = va[0]; bus.acc1 = va[1]; bus.acc2 = va[2]; bus.acc3 = va[3];
        bus.exp0 = ve[0]; bus.exp1 = ve[1]; bus.exp2 = ve[2]; bus.exp3 = ve[3];
    endtask

    task automatic scramble_inputs();
        bus.acc0 = $urandom; bus.acc1 = $urandom; bus.acc2 = $urandom; bus.acc3 = $urandom;
        bus.exp0 = 10'($urandom); bus.exp1 = 10'($urandom);
        bus.exp2 = 10'($urandom); bus.exp3 = 10'($urandom);
        bus.lane_en = 4'($urandom);
    endtask

    // Drains lanes en, expecting ed_arr/ef_arr; inputs are scrambled after start.
    task automatic run_drain(input logic [3:0] en, input int stall_min, input int stall_max);
        int n;
        int stall;
        @(negedge clk);
        bus.start = 1'b1;
        bus.lane_en = en;
        drive_lanes();
        @(negedge clk);
        bus.start = 1'b0;
        scramble_inputs();
        if (en == 4'd0) begin
            check("done after empty start", 32'(bus.done), 32'd1);
            check("valid on empty drain", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check("done width empty", 32'(bus.done), 32'd0);
            check("busy after empty", 32'(bus.busy), 32'd0);
            return;
        end
        check("busy after start", 32'(bus.busy), 32'd1);
        for (int ln = 0; ln < 4; ln++) begin
            if (!en[ln]) continue;
            n = 0;
            while (!bus.out_valid && n < 10) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            check($sformatf("latency lane%0d", ln), 32'(n), 32'd3);
            if (!bus.out_valid) return;
            check($sformatf("idx lane%0d", ln), 32'(bus.out_idx), 32'(ln));
            check($sformatf("data lane%0d", ln), bus.out_data, ed_arr[ln]);
            check($sformatf("flag lane%0d", ln), 32'(bus.out_flag), 32'(ef_arr[ln]));
            check($sformatf("done early lane%0d", ln), 32'(bus.done), 32'd0);
            bus.out_ready = 1'b0;
            stall = $urandom_range(stall_min, stall_max);
            repeat (stall) begin
                bus.start = 1'($urandom_range(0, 1));
                @(negedge clk);
                check($sformatf("held valid lane%0d", ln), 32'(bus.out_valid), 32'd1);
                check($sformatf("held data lane%0d", ln), bus.out_data, ed_arr[ln]);
                check($sformatf("held idx lane%0d", ln), 32'(bus.out_idx), 32'(ln));
            end
            bus.start = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("valid drop lane%0d", ln), 32'(bus.out_valid), 32'd0);
        end
        check("done pulse", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("done single cycle", 32'(bus.done), 32'd0);
        check("busy at end", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  f;
        int n;
        logic [3:0] en;

        tbl[0]  = '{32'h4000_0000, 10'd254, 32'h3F80_0000, 5'b00000};
        tbl[1]  = '{32'hA000_0000, 10'd254, 32'hBFC0_0000, 5'b00000};
        tbl[2]  = '{32'h7FFF_FFFF, 10'd254, 32'h4000_0000, 5'b00001};
        tbl[3]  = '{32'h4000_0000, 10'd511, 32'h7F80_0000, 5'b00101};
        tbl[4]  = '{32'h0000_0001, 10'd0,   32'h0000_0000, 5'b00011};
        tbl[5]  = '{32'h0000_0000, 10'd100, 32'h0000_0000, 5'b00000};
        tbl[6]  = '{32'h8000_0000, 10'd254, 32'hC000_0000, 5'b00000};
        tbl[7]  = '{32'h0000_0001, 10'd135, 32'h0000_0001, 5'b00000};
        tbl[8]  = '{32'h0000_0001, 10'd134, 32'h0000_0000, 5'b00011};
        tbl[9]  = '{32'hFFFF_FFFF, 10'd134, 32'h8000_0000, 5'b00011};
        tbl[10] = '{32'h0000_0003, 10'd134, 32'h0000_0002, 5'b00011};
        tbl[11] = '{32'h4000_0000, 10'd381, 32'h7F00_0000, 5'b00000};
        tbl[12] = '{32'h4000_0000, 10'd382, 32'h7F80_0000, 5'b00101};
        tbl[13] = '{32'h0100_0001, 10'd284, 32'h4B80_0000, 5'b00001};
        tbl[14] = '{32'h0100_0003, 10'd284, 32'h4B80_0002, 5'b00001};
        tbl[15] = '{32'h00FF_FFFF, 10'd134, 32'h0080_0000, 5'b00001};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.lane_en = 4'd0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin va[i] = 32'd0; ve[i] = 10'd0; end
        drive_lanes();
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset out_flag", 32'(bus.out_flag), 32'd0);
        check("reset out_idx", 32'(bus.out_idx), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table: the model must agree with the hand-derived constants too.
        for (int i = 0; i < 16; i++) begin
            int ln;
            ln = i % 4;
            ref_conv(tbl[i].acc, tbl[i].exp, d, f);
            check($sformatf("model data vec%0d", i), d, tbl[i].data);
            check($sformatf("model flag vec%0d", i), 32'(f), 32'(tbl[i].flag));
            for (int j = 0; j < 4; j++) begin va[j] = $urandom; ve[j] = 10'($urandom); end
            va[ln] = tbl[i].acc;
            ve[ln] = tbl[i].exp;
            ed_arr[ln] = tbl[i].data;
            ef_arr[ln] = tbl[i].flag;
            run_drain(4'b0001 << ln, 0, 2);
        end

        // All lanes zero, consumer stalls 5 cycles per lane, inputs scrambled after start.
        for (int j = 0; j < 4; j++) begin
            va[j] = 32'd0; ve[j] = 10'($urandom);
            ed_arr[j] = 32'd0; ef_arr[j] = 5'd0;
        end
        run_drain(4'b1111, 5, 5);

        // Empty lane mask.
        run_drain(4'b0000, 0, 0);

        // Reset while lane 2 is presented.
        for (int j = 0; j < 4; j++) begin va[j] = $urandom; ve[j] = 10'd254; end
        @(negedge clk);
        bus.start = 1'b1;
        bus.lane_en = 4'b1111;
        drive_lanes();
        @(negedge clk);
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (!(bus.out_valid && bus.out_idx == 2'd2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach lane2 before abort", 32'(bus.out_valid && bus.out_idx == 2'd2), 32'd1);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no done after abort", 32'(bus.done), 32'd0);
            check("no valid after abort", 32'(bus.out_valid), 32'd0);
        end

        // Random drains against the model.
        for (int t = 0; t < 60; t++) begin
            for (int j = 0; j < 4; j++) begin
                va[j] = $urandom;
                case ($urandom_range(0, 3))
                    0: va[j] = va[j] >> $urandom_range(0, 31);
                    1: va[j] = 32'($signed(va[j]) >>> $urandom_range(0, 31));
                    default: ;
                endcase
                case ($urandom_range(0, 3))
                    0: ve[j] = 10'($urandom);
                    1: ve[j] = 10'($urandom_range(100, 180));
                    2: ve[j] = 10'($urandom_range(370, 420));
                    default: ve[j] = 10'($urandom_range(230, 300));
                endcase
                ref_conv(va[j], ve[j], ed_arr[j], ef_arr[j]);
            end
            en = 4'($urandom);
            run_drain(en, 0, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
